// File: rtl/clock_time_ctrl.sv
// Clock sequencer: 1 Hz timebase, cascaded counter enables,
// button-driven time-set FSM and field blink for the display.
module clock_time_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sec_last,
  input  logic       min_last,
  input  logic       hr_last,
  output logic       sec_ena,
  output logic       min_ena,
  output logic       hr_ena,
  output logic       sec_clr,
  output logic       day_pulse,
  output logic [1:0] mode,
  output logic [2:0] disp_on
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLNK_MAX = BW'(BLINK_DIV - 1);

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] SET_HR  = 2'b01;
  localparam logic [1:0] SET_MIN = 2'b10;
  localparam logic [1:0] SET_SEC = 2'b11;

  logic [1:0]    r_state;
  logic [TW-1:0] r_pre;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic          r_resync;
  logic          r_ms1, r_ms2, r_mprev, r_mpress;
  logic          r_is1, r_is2, r_iprev, r_ipress;
  logic          r_sec_ena, r_min_ena, r_hr_ena;
  logic          r_sec_clr, r_day;
  logic [2:0]    r_disp;

  logic          w_mode_p, w_inc_p, w_run, w_tick;
  logic          w_leave, w_clr_pre, w_run_tick;
  logic [1:0]    w_state_nxt;
  logic [BW-1:0] w_bcnt_nxt;
  logic          w_phase_nxt;
  logic [2:0]    w_disp_nxt;

  always_comb begin
    w_mode_p    = r_mpress;
    w_inc_p     = r_ipress & ~r_mpress;
    w_run       = (r_state == RUN);
    w_tick      = (r_pre == TICK_MAX);
    w_run_tick  = w_run & w_tick;
    w_leave     = (r_state == SET_SEC) & w_mode_p;
    // Hold the prescaler at 0 for two edges so the first
    // tick after leaving set mode is a full period later.
    w_clr_pre   = w_leave | r_resync;
    w_state_nxt = r_state;
    if (w_mode_p) w_state_nxt = r_state + 2'd1;
    w_bcnt_nxt  = r_bcnt;
    w_phase_nxt = r_phase;
    if (w_state_nxt == RUN) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = 1'b1;
    end else if (w_run) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (r_bcnt == BLNK_MAX) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = ~r_phase;
    end else begin
      w_bcnt_nxt  = r_bcnt + BW'(1);
    end
    w_disp_nxt = 3'b111;
    unique case (1'b1)
      (w_state_nxt == SET_HR):  w_disp_nxt = {w_phase_nxt, 2'b11};
      (w_state_nxt == SET_MIN): w_disp_nxt = {1'b1, w_phase_nxt, 1'b1};
      (w_state_nxt == SET_SEC): w_disp_nxt = {2'b11, w_phase_nxt};
      default:                  w_disp_nxt = 3'b111;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_pre     <= '0;
      r_bcnt    <= '0;
      r_phase   <= 1'b1;
      r_resync  <= 1'b0;
      r_ms1     <= 1'b0;
      r_ms2     <= 1'b0;
      r_mprev   <= 1'b0;
      r_mpress  <= 1'b0;
      r_is1     <= 1'b0;
      r_is2     <= 1'b0;
      r_iprev   <= 1'b0;
      r_ipress  <= 1'b0;
      r_sec_ena <= 1'b0;
      r_min_ena <= 1'b0;
      r_hr_ena  <= 1'b0;
      r_sec_clr <= 1'b0;
      r_day     <= 1'b0;
      r_disp    <= 3'b111;
    end else begin
      r_ms1     <= mode_btn;
      r_ms2     <= r_ms1;
      r_mprev   <= r_ms2;
      r_mpress  <= r_ms2 & ~r_mprev;
      r_is1     <= inc_btn;
      r_is2     <= r_is1;
      r_iprev   <= r_is2;
      r_ipress  <= r_is2 & ~r_iprev;
      r_state   <= w_state_nxt;
      r_resync  <= w_leave;
      r_bcnt    <= w_bcnt_nxt;
      r_phase   <= w_phase_nxt;
      r_disp    <= w_disp_nxt;
      if (w_clr_pre || w_tick) r_pre <= '0;
      else                     r_pre <= r_pre + TW'(1);
      r_sec_ena <= w_run_tick;
      r_min_ena <= (w_run_tick & sec_last)
                 | (w_inc_p & (r_state == SET_MIN));
      r_hr_ena  <= (w_run_tick & sec_last & min_last)
                 | (w_inc_p & (r_state == SET_HR));
      r_day     <= w_run_tick & sec_last & min_last & hr_last;
      r_sec_clr <= w_inc_p & (r_state == SET_SEC);
    end
  end

  assign sec_ena   = r_sec_ena;
  assign min_ena   = r_min_ena;
  assign hr_ena    = r_hr_ena;
  assign sec_clr   = r_sec_clr;
  assign day_pulse = r_day;
  assign mode      = r_state;
  assign disp_on   = r_disp;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl with short dividers:
// cascade table plus hand sequences for set modes and reset.
module tb_clock_time_ctrl;

  localparam int TD = 5;
  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       sec_last = 1'b0;
  logic       min_last = 1'b0;
  logic       hr_last = 1'b0;
  logic       sec_ena, min_ena, hr_ena, sec_clr, day_pulse;
  logic [1:0] mode;
  logic [2:0] disp_on;

  clock_time_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .sec_last  (sec_last),
    .min_last  (min_last),
    .hr_last   (hr_last),
    .sec_ena   (sec_ena),
    .min_ena   (min_ena),
    .hr_ena    (hr_ena),
    .sec_clr   (sec_clr),
    .day_pulse (day_pulse),
    .mode      (mode),
    .disp_on   (disp_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_sec = 0, n_min = 0, n_hr = 0, n_clr = 0, n_day = 0;

  always @(negedge clk) begin
    if (sec_ena)   n_sec++;
    if (min_ena)   n_min++;
    if (hr_ena)    n_hr++;
    if (sec_clr)   n_clr++;
    if (day_pulse) n_day++;
  end

  typedef struct {
    logic s, m, h;
    logic [2:0] e;
  } cas_t;

  cas_t       vec [8];
  logic [2:0] sb_q [$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  task automatic clr_cnt();
    n_sec = 0; n_min = 0; n_hr = 0; n_clr = 0; n_day = 0;
  endtask

  task automatic wait_sec(output int n);
    n = 999;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (sec_ena) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    repeat (4) step();
    mode_btn = 1'b0;
  endtask

  task automatic press_inc();
    inc_btn = 1'b1;
    repeat (4) step();
    inc_btn = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_mode"}, mode, 2'b00);
    chk({nm, "_disp"}, disp_on, 3'b111);
    chk({nm, "_pulses"},
        {sec_ena, min_ena, hr_ena, sec_clr, day_pulse}, 5'b0);
  endtask

  int         n;
  int         found;
  logic [2:0] e;

  initial begin
    // {sec_last,min_last,hr_last} -> {min_ena,hr_ena,day_pulse}
    vec[0] = '{1'b0, 1'b0, 1'b0, 3'b000};
    vec[1] = '{1'b1, 1'b0, 1'b0, 3'b100};
    vec[2] = '{1'b0, 1'b1, 1'b0, 3'b000};
    vec[3] = '{1'b1, 1'b1, 1'b0, 3'b110};
    vec[4] = '{1'b0, 1'b0, 1'b1, 3'b000};
    vec[5] = '{1'b1, 1'b0, 1'b1, 3'b100};
    vec[6] = '{1'b0, 1'b1, 1'b1, 3'b000};
    vec[7] = '{1'b1, 1'b1, 1'b1, 3'b111};

    repeat (3) step();
    chk_idle("reset");
    reset = 1'b1;
    wait_sec(n);
    chk("first_tick", n, TD);
    chk("no_cascade", {min_ena, hr_ena}, 2'b00);
    wait_sec(n);
    chk("tick_period", n, TD);
    step();
    chk("tick_width", sec_ena, 1'b0);

    for (int i = 0; i < 8; i++) begin
      sec_last = vec[i].s;
      min_last = vec[i].m;
      hr_last  = vec[i].h;
      sb_q.push_back(vec[i].e);
      wait_sec(n);
      chk("cas_seen", n <= TD, 1'b1);
      e = sb_q.pop_front();
      chk("cascade", {min_ena, hr_ena, day_pulse}, e);
    end
    sec_last = 1'b1;
    min_last = 1'b1;
    hr_last  = 1'b1;

    // Enter SET_HR and watch the blanked-first blink.
    mode_btn = 1'b1;
    repeat (3) step();
    chk("mode_lat_pre", mode, 2'b00);
    step();
    chk("mode_hr", mode, 2'b01);
    chk("blink0", disp_on, 3'b011);
    repeat (3) step();
    chk("blink0_hold", disp_on, 3'b011);
    step();
    chk("blink1", disp_on, 3'b111);
    repeat (4) step();
    chk("blink2", disp_on, 3'b011);
    mode_btn = 1'b0;
    drain();
    chk("held_once", mode, 2'b01);

    clr_cnt();
    repeat (3) begin
      press_inc();
      drain();
    end
    chk("hr_inc_cnt", n_hr, 3);
    chk("hr_inc_min", n_min, 0);
    chk("hr_inc_sec", n_sec, 0);
    chk("hr_inc_day", n_day, 0);

    press_mode();
    drain();
    chk("mode_min", mode, 2'b10);
    clr_cnt();
    press_inc();
    drain();
    chk("min_inc_cnt", n_min, 1);
    chk("min_inc_hr", n_hr, 0);
    chk("min_inc_sec", n_sec + n_clr, 0);

    press_mode();
    drain();
    chk("mode_sec", mode, 2'b11);
    clr_cnt();
    press_inc();
    chk("sec_clr_on", sec_clr, 1'b1);
    step();
    chk("sec_clr_off", sec_clr, 1'b0);
    drain();
    chk("sec_clr_cnt", n_clr, 1);
    chk("set_no_tick", n_sec, 0);

    sec_last = 1'b0;
    min_last = 1'b0;
    hr_last  = 1'b0;
    press_mode();
    chk("mode_run", mode, 2'b00);
    wait_sec(n);
    chk("resync_tick", n, TD + 1);
    drain();

    // Simultaneous presses in RUN: mode wins.
    clr_cnt();
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    repeat (4) step();
    chk("both_mode", mode, 2'b01);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (6) step();
    chk("both_no_hr", n_hr, 0);

    press_mode();
    drain();
    chk("mode_min2", mode, 2'b10);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (disp_on[1] == 1'b0) begin
        found = 1;
        break;
      end
      step();
    end
    chk("blink_low_seen", found, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("async_rst");
    step();
    step();
    reset = 1'b1;
    wait_sec(n);
    chk("post_rst_tick", n, TD);
    chk("post_rst_mode", mode, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
